// File: rtl/intt_stream_if.sv
`default_nettype none
// ============================================================================
// Module      : intt_stream_if
// Description : Stream bundle for intt_stream. The coefficient input and the
//               sample output each use a valid/ready handshake.
//               master = producer/consumer side, slave = intt_stream side.
// Revision    : 1.0 - initial release
// ============================================================================
interface intt_stream_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_index;
    logic        out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_index, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_index, out_last
    );
endinterface
`default_nettype wire

// File: rtl/intt_stream.sv
`default_nettype none
// ============================================================================
// Module      : intt_stream
// Description : Streaming 16-point inverse NTT modulo Q. Accepts X[0..15] in
//               order, accumulates all 16 outputs in parallel, optionally
//               scales by NINV, then emits x[0..15] with index and last flag.
// Config      : INTT_SCALE_EN - when defined, a SCALE phase multiplies every
//               accumulator by NINV before emission. When undefined, the raw
//               sum (16*x[n] mod Q) is emitted straight after X[15].
// Revision    : 1.0 - initial release
// ============================================================================
module intt_stream #(
    parameter int Q    = 7681,
    parameter int NINV = 7201
) (
    input  wire logic      clk,
    input  wire logic      rst,
    intt_stream_if.slave   bus
);

    localparam logic [31:0] c_Q    = 32'(Q);
    localparam int          c_NPTS = 16;

    typedef enum logic [1:0] {
        S_ACCUM = 2'd0,
`ifdef INTT_SCALE_EN
        S_SCALE = 2'd1,
`endif
        S_EMIT  = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_k;          // input index in ACCUM, scale index in SCALE
    logic [3:0]  r_outIdx;
    logic        r_inReady;
    logic        r_outValid;
    logic        r_outLast;
    logic [31:0] r_acc [c_NPTS];

    logic [31:0] w_xRed;
    logic [31:0] w_accSum [c_NPTS];
    logic        w_inFire;
    logic        w_outFire;

    // Powers of omega^-1; index is the exponent mod 16.
    function automatic logic [31:0] twiddle(input logic [3:0] idx);
        logic [31:0] w;
        case (idx)
            4'd0:    w = 32'd1;
            4'd1:    w = 32'd7154;
            4'd2:    w = 32'd1213;
            4'd3:    w = 32'd5953;
            4'd4:    w = 32'd4298;
            4'd5:    w = 32'd849;
            4'd6:    w = 32'd5756;
            4'd7:    w = 32'd583;
            4'd8:    w = 32'd7680;
            4'd9:    w = 32'd527;
            4'd10:   w = 32'd6468;
            4'd11:   w = 32'd1728;
            4'd12:   w = 32'd3383;
            4'd13:   w = 32'd6832;
            4'd14:   w = 32'd1925;
            default: w = 32'd7098;
        endcase
        return w;
    endfunction

    // Reduced coefficient is < Q, so X*W < Q^2 and acc + X*W fits in 32 bits.
    assign w_xRed    = bus.in_data % c_Q;
    assign w_inFire  = bus.in_valid && r_inReady;
    assign w_outFire = r_outValid && bus.out_ready;

    generate
        for (genvar n = 0; n < c_NPTS; n++) begin : g_acc
            localparam logic [3:0] c_N = 4'(n);
            logic [3:0]  w_exp;
            logic [31:0] w_prod;
            // 4-bit product wraps naturally, giving (k*n) mod 16.
            assign w_exp       = r_k * c_N;
            assign w_prod      = w_xRed * twiddle(w_exp);
            assign w_accSum[n] = (r_acc[n] + w_prod) % c_Q;
        end
    endgenerate

`ifdef INTT_SCALE_EN
    localparam logic [31:0] c_NINV = 32'(NINV);
    logic [31:0] w_scaled;
    assign w_scaled = (r_acc[r_k] * c_NINV) % c_Q;
`else
    logic [31:0] w_unused_ninv;
    assign w_unused_ninv = 32'(NINV);
`endif

    // Frame controller: accumulate inputs, optionally scale, then emit samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_ACCUM;
            r_k        <= 4'd0;
            r_outIdx   <= 4'd0;
            r_inReady  <= 1'b1;
            r_outValid <= 1'b0;
            r_outLast  <= 1'b0;
            for (int n = 0; n < c_NPTS; n++) begin
                r_acc[n] <= 32'd0;
            end
        end else begin
            case (r_state)
                S_ACCUM: begin
                    if (w_inFire) begin
                        for (int n = 0; n < c_NPTS; n++) begin
                            r_acc[n] <= w_accSum[n];
                        end
                        r_k <= r_k + 4'd1;     // wraps to 0 after k=15
                        if (r_k == 4'd15) begin
                            r_inReady <= 1'b0;
`ifdef INTT_SCALE_EN
                            r_state   <= S_SCALE;
`else
                            r_state    <= S_EMIT;
                            r_outValid <= 1'b1;
                            r_outLast  <= 1'b0;
`endif
                        end
                    end
                end
`ifdef INTT_SCALE_EN
                S_SCALE: begin
                    r_acc[r_k] <= w_scaled;
                    r_k        <= r_k + 4'd1;
                    if (r_k == 4'd15) begin
                        r_state    <= S_EMIT;
                        r_outValid <= 1'b1;
                        r_outLast  <= 1'b0;
                    end
                end
`endif
                S_EMIT: begin
                    if (w_outFire) begin
                        if (r_outIdx == 4'd15) begin
                            for (int n = 0; n < c_NPTS; n++) begin
                                r_acc[n] <= 32'd0;
                            end
                            r_outIdx   <= 4'd0;
                            r_state    <= S_ACCUM;
                            r_inReady  <= 1'b1;
                            r_outValid <= 1'b0;
                            r_outLast  <= 1'b0;
                        end else begin
                            r_outIdx  <= r_outIdx + 4'd1;
                            r_outLast <= (r_outIdx == 4'd14);
                        end
                    end
                end
                default: begin
                    r_state <= S_ACCUM;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_inReady;
    assign bus.out_valid = r_outValid;
    assign bus.out_data  = r_acc[r_outIdx];
    assign bus.out_index = r_outIdx;
    assign bus.out_last  = r_outLast;

endmodule
`default_nettype wire

// File: doc/intt_stream.md
INTT_STREAM -- requirements
Module: intt_stream

Interface
REQ-001 SHALL have parameter: Q, 7681, modulus.
REQ-002 SHALL have parameter: NINV, 7201, 16^-1 mod Q.
REQ-003 SHALL have port: clk  input  1  clock.
REQ-004 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port: in_valid  input  1  input coefficient valid.
REQ-006 SHALL have port: in_ready  output  1  block accepts input.
REQ-007 SHALL have port: in_data  input  32  NTT-domain coefficient X[k], k implied by accept order 0..15.
REQ-008 SHALL have port: out_valid  output  1  output sample valid.
REQ-009 SHALL have port: out_ready  input  1  consumer accepts output.
REQ-010 SHALL have port: out_data  output  32  time-domain sample x[n].
REQ-011 SHALL have port: out_index  output  4  n of the current out_data.
REQ-012 SHALL have port: out_last  output  1  high with out_valid when out_index==15.

Function
REQ-013 SHALL compute the 16-point inverse NTT mod Q: x[n] = NINV * sum_k X[k]*W[(k*n) mod 16] mod Q.
REQ-014 SHALL use fixed table W[0..15] = 1,7154,1213,5953,4298,849,5756,583,7680,527,6468,1728,3383,6832,1925,7098 (powers of omega^-1, omega=7098).
REQ-015 SHALL hold 16 accumulators acc[0..15], 32-bit, each always in [0,Q-1].
REQ-016 SHALL reduce in_data mod Q before use; all products are below 2^32 and need no wider intermediate.
REQ-017 SHALL implement states ACCUM, SCALE, EMIT; state encoding is free.
REQ-018 ACCUM: in_ready=1; on in_valid&in_ready edge, all 16 acc[n] <= (acc[n] + X*W[(k*n) mod 16]) mod Q in parallel, k increments.
REQ-019 ACCUM: in_valid low SHALL leave acc and k unchanged; no timeout.
REQ-020 The edge accepting k=15 SHALL move state to SCALE and clear k to 0.
REQ-021 SCALE: one accumulator per cycle, acc[i] <= acc[i]*NINV mod Q, i=0..15; after the edge processing i=15, state=EMIT.
REQ-022 SCALE and EMIT: in_ready=0; in_valid ignored.
REQ-023 EMIT: out_valid=1, out_data=acc[out_index], out_index starts at 0.
REQ-024 EMIT: out_index SHALL advance only on an out_valid&out_ready edge; out_data and out_index SHALL stay stable while out_ready=0.
REQ-025 The edge accepting out_index=15 SHALL clear all acc, set out_index=0, and return to ACCUM; in_ready=1 the next cycle.
REQ-026 out_valid SHALL be 0 outside EMIT; out_data is don't-care when out_valid=0.
REQ-027 Latency, scaling enabled: out_valid rises 16 clock edges after the edge accepting X[15].

Reset
REQ-028 rst SHALL set state=ACCUM, k=0, out_index=0, all acc=0, out_valid=0, out_last=0, in_ready=1 on the next cycle.
REQ-029 rst SHALL take priority over any handshake in the same cycle and abort any state mid-operation; partial frames are discarded.

Configuration
REQ-030 Macro INTT_SCALE_EN defined: SCALE state exists, and outputs are multiplied by NINV per REQ-021.
REQ-031 INTT_SCALE_EN undefined: no SCALE state and no NINV multiplier; the edge accepting X[15] goes directly to EMIT, out_valid rises the next cycle, and out_data is the unscaled sum (16*x[n] mod Q).

Verification
REQ-032 Enabled, X=[1,1,...,1] -> x=[1,0,0,...,0]; out_last only on index 15.
REQ-033 Enabled, X=[1,0,...,0] -> every x[n]=7201; undefined macro -> every x[n]=1.
REQ-034 Enabled, X[k]=7681+5 at k=0, other X=0 -> all outputs 5*7201 mod 7681 = 5*7201%7681 (=5 * 7201 reduced, i.e. 5 * x of REQ-033).
REQ-035 out_ready held low 5 cycles at out_index=3 -> out_data/out_index unchanged for 5 cycles, then 4..15 emitted in order.
REQ-036 in_valid gaps during ACCUM, then rst asserted during EMIT at out_index=7 -> out_valid=0, in_ready=1 after reset; next frame X=[1,1,...] yields [1,0,...,0].
